// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit a + b + cin, DIGIT bits per clock, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub input (a - b) and the signed-overflow output ovf.
module serial_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
   output logic             ovf,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = ($clog2(STEPS + 1) < 1) ? 1 : $clog2(STEPS + 1);
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_nxt;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [DIGIT:0]   slice;
   logic             load, last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (cnt == LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      load = (state == IDLE) && start;
      last = (state == RUN) && (cnt == LAST);
   end

   always_comb begin
      slice = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
      // New digit enters at the top; the concatenation keeps DIGIT == WIDTH legal
      res_nxt = WIDTH'({slice[DIGIT-1:0], res_reg} >> DIGIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg   <= '0;
         b_reg   <= '0;
         res_reg <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         done    <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
         ovf     <= 1'b0;
`endif
      end else begin
         done <= last;
         if (load) begin
            a_reg <= a;
`ifdef SERIAL_ADDER_SUB_EN
            b_reg <= sub ? ~b : b;
            carry <= sub | cin;
`else
            b_reg <= b;
            carry <= cin;
`endif
            cnt   <= '0;
         end else if (busy) begin
            a_reg   <= a_reg >> DIGIT;
            b_reg   <= b_reg >> DIGIT;
            res_reg <= res_nxt;
            carry   <= slice[DIGIT];
            cnt     <= cnt + CW'(1);
            if (last) begin
               sum  <= res_nxt;
               cout <= slice[DIGIT];
`ifdef SERIAL_ADDER_SUB_EN
               // carry into the MSB recovered from the MSB sum bit and its operands
               ovf  <= slice[DIGIT-1] ^ a_reg[DIGIT-1] ^ b_reg[DIGIT-1] ^ slice[DIGIT];
`endif
            end
         end
      end
   end

endmodule
